mac_frame_accum: RTL

//  Downstream stage of the registered multiply-add unit (DATA_OUT <= A*B+C).

---
 rtl/mac_frame_accum.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mac_frame_accum.sv
`default_nettype none
// ============================================================================
//  Module      : mac_frame_accum
//  Description : Sums frames of N_SAMPLES multiply-add results and presents
//                each frame sum on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_frame_accum #(
  parameter int DW        = 16,
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 19,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [DW-1:0]    data_in,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             drop_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_SAMPLES - 1);

  state_t           r_state, w_state_n;
  logic [ACC_W-1:0] r_acc, w_acc_n;
  logic [CNT_W-1:0] r_count, w_count_n;
  logic [ACC_W-1:0] r_sum, w_sum_n;
  logic             r_sum_valid, w_sum_valid_n;
  logic             r_drop_err, w_drop_err_n;
  logic             r_busy;

  logic [ACC_W-1:0] w_sample;
  logic             w_accept;

  assign w_sample = {{(ACC_W-DW){1'b0}}, data_in};
  assign w_accept = r_sum_valid && sum_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_drop_err  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_acc       <= w_acc_n;
      r_count     <= w_count_n;
      r_sum       <= w_sum_n;
      r_sum_valid <= w_sum_valid_n;
      r_drop_err  <= w_drop_err_n;
      r_busy      <= (w_state_n != S_IDLE);
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_acc_n       = r_acc;
    w_count_n     = r_count;
    w_sum_n       = r_sum;
    w_sum_valid_n = r_sum_valid;
    w_drop_err_n  = r_drop_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n    = S_ACCUM;
          w_acc_n      = '0;
          w_count_n    = '0;
          w_drop_err_n = 1'b0;
        end
      end
      S_ACCUM: begin
        if (start) begin
          // A sample coinciding with the restart opens the new frame
          w_drop_err_n = 1'b0;
          w_acc_n      = in_valid ? w_sample : '0;
          w_count_n    = in_valid ? CNT_W'(1) : '0;
        end else if (in_valid) begin
          if (r_count == c_LAST) begin
            w_sum_n       = r_acc + w_sample;
            w_sum_valid_n = 1'b1;
            w_acc_n       = '0;
            w_count_n     = '0;
            w_state_n     = S_HOLD;
          end else begin
            w_acc_n   = r_acc + w_sample;
            w_count_n = r_count + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (w_accept) begin
          w_sum_valid_n = 1'b0;
          if (start) begin
            w_state_n    = S_ACCUM;
            w_drop_err_n = 1'b0;
            w_acc_n      = in_valid ? w_sample : '0;
            w_count_n    = in_valid ? CNT_W'(1) : '0;
          end else begin
            w_state_n = S_IDLE;
          end
        end
        // Samples are only consumed in HOLD when a new frame begins
        if (in_valid && !(w_accept && start)) begin
          w_drop_err_n = 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign sum_out   = r_sum;
  assign sum_valid = r_sum_valid;
  assign busy      = r_busy;
  assign count     = r_count;
  assign drop_err  = r_drop_err;

endmodule
`default_nettype wire
